// File: rtl/risc_boot_loader.sv
// rtl/risc_boot_loader.sv - byte-stream program loader and run controller for the Risc core
//
// Receives a frame {N[7:0], N[15:8], N little-endian 32-bit words}, writes each
// word into instruction memory, then enables the core until it raises halt.
//
// Optional feature macro: CHECKSUM_EN
//   defined   - one trailer byte follows the last word. It must equal the XOR
//               of all earlier frame bytes, or the load ends in ERR.
//   undefined - no trailer. The last write goes straight to RUN.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a load (honoured in IDLE/DONE/ERR only)
//   in_valid/in_ready  byte stream handshake, in_data = byte
//   im_addr/im_datain  instruction-memory word address / write data
//   im_wen             instruction-memory write enable, active low
//   core_en / halt     core enable out, core halt in
//   busy/done/err      status flags
//   cycles             core run cycles before halt (saturating)
module risc_boot_loader #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048,
   parameter int CYC_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [DATA_WIDTH-1:0] im_datain,
   output logic                  im_wen,
   output logic                  core_en,
   input  logic                  halt,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [CYC_WIDTH-1:0]  cycles
);

   typedef enum logic [3:0] {
      S_IDLE, S_LEN0, S_LEN1, S_WORD, S_WRITE, S_CHK, S_RUN, S_DONE, S_ERR
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_in_ready;
   logic                  r_im_wen;
   logic                  r_core_en;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;
   logic [ADDR_WIDTH-1:0] r_im_addr;
   logic [DATA_WIDTH-1:0] r_im_datain;
   logic [CYC_WIDTH-1:0]  r_cycles;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [15:0]           r_n;
   logic [15:0]           r_index;
   logic [1:0]            r_bcnt;

   logic                  w_xfer;
   logic                  w_launch;
   logic [15:0]           w_len;
   logic                  w_len_bad;
   logic                  w_last;
   logic [DATA_WIDTH-1:0] w_word;

   assign w_xfer    = in_valid & r_in_ready;
   assign w_launch  = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
   // Full length is only known while the high byte is on the bus.
   assign w_len     = {in_data, r_n[7:0]};
   assign w_len_bad = (w_len == 16'd0) || (32'(w_len) > 32'(DEPTH));
   assign w_last    = (r_index == (r_n - 16'd1));
   // Little-endian: bytes enter at the top and drift down, byte 0 ends at [7:0].
   assign w_word    = {in_data, r_shift[DATA_WIDTH-1:8]};

`ifdef CHECKSUM_EN
   logic [7:0] r_chk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk <= 8'd0;
      end else if (w_launch) begin
         r_chk <= 8'd0;
      end else if (w_xfer && (r_state != S_CHK)) begin
         r_chk <= r_chk ^ in_data;
      end
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: if (start) w_next = S_LEN0;
         S_LEN0:  if (w_xfer) w_next = S_LEN1;
         S_LEN1:  if (w_xfer) w_next = w_len_bad ? S_ERR : S_WORD;
         S_WORD:  if (w_xfer && (r_bcnt == 2'd3)) w_next = S_WRITE;
         S_WRITE: begin
            if (w_last) begin
`ifdef CHECKSUM_EN
               w_next = S_CHK;
`else
               w_next = S_RUN;
`endif
            end else begin
               w_next = S_WORD;
            end
         end
         S_CHK: begin
`ifdef CHECKSUM_EN
            if (w_xfer) w_next = (in_data == r_chk) ? S_RUN : S_ERR;
`else
            w_next = S_IDLE;
`endif
         end
         S_RUN:   if (halt) w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet
   // line up with the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_im_wen    <= 1'b1;
         r_core_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_im_addr   <= '0;
         r_im_datain <= '0;
         r_cycles    <= '0;
         r_shift     <= '0;
         r_n         <= 16'd0;
         r_index     <= 16'd0;
         r_bcnt      <= 2'd0;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next == S_LEN0) || (w_next == S_LEN1) ||
                       (w_next == S_WORD) || (w_next == S_CHK);
         r_im_wen   <= (w_next != S_WRITE);
         r_core_en  <= (w_next == S_RUN);
         r_busy     <= !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_ERR));
         r_done     <= (w_next == S_DONE);
         r_err      <= (w_next == S_ERR);

         if (w_launch) begin
            r_cycles <= '0;
            r_index  <= 16'd0;
            r_bcnt   <= 2'd0;
         end
         if (w_xfer && (r_state == S_LEN0)) r_n <= {8'd0, in_data};
         if (w_xfer && (r_state == S_LEN1)) r_n <= w_len;
         if (w_xfer && (r_state == S_WORD)) begin
            r_shift <= w_word;
            r_bcnt  <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
               r_im_addr   <= ADDR_WIDTH'(r_index);
               r_im_datain <= w_word;
            end
         end
         if ((r_state == S_WRITE) && !w_last) r_index <= r_index + 16'd1;
         if ((r_state == S_RUN) && !halt && (r_cycles != {CYC_WIDTH{1'b1}}))
            r_cycles <= r_cycles + CYC_WIDTH'(1);
      end
   end

   assign in_ready  = r_in_ready;
   assign im_wen    = r_im_wen;
   assign im_addr   = r_im_addr;
   assign im_datain = r_im_datain;
   assign core_en   = r_core_en;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign cycles    = r_cycles;

endmodule
